// File: rtl/cpu_timing_if.sv
// Front-panel / memory bundle between the timing generator and its environment.
// The master drives run/step control and memory data; the slave (timing generator) returns beat state.
interface cpu_timing_if #(
    parameter int IR_W  = 16,
    parameter int CNT_W = 16
);
    logic             run;
    logic             single_step;
    logic             step;
    logic             mem_ready;
    logic [IR_W-1:0]  mem_data;
    logic [2:0]       timer;
    logic [IR_W-1:0]  instruction;
    logic             ir_loaded;
    logic             stalled;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output run, single_step, step, mem_ready, mem_data,
        input  timer, instruction, ir_loaded, stalled, instr_count
    );

    modport slave (
        input  run, single_step, step, mem_ready, mem_data,
        output timer, instruction, ir_loaded, stalled, instr_count
    );
endinterface

// File: rtl/cpu_timing_gen.sv
// Beat sequencer for the instruction controller: steps through fetch/execute/memory beats,
// latches the fetched word into the IR and counts retired instructions.
module cpu_timing_gen #(
    parameter int              IR_W     = 16,
    parameter int              CNT_W    = 16,
    parameter logic [IR_W-1:0] IR_RESET = '0
) (
    input  logic           clk,
    input  logic           rst,
    cpu_timing_if.slave    bus
);

    // The state encoding is the beat code the controller decodes.
    typedef enum logic [2:0] {
        S_INIT = 3'b100,
        S_FADR = 3'b000,
        S_FRD  = 3'b001,
        S_EXEC = 3'b011,
        S_MADR = 3'b101,
        S_MDAT = 3'b111
    } state_e;

    state_e           state_q, state_d;
    logic [IR_W-1:0]  ir_q;
    logic [CNT_W-1:0] count_q;
    logic             loaded_q;
    logic             step_q;

    logic adv;
    logic is_mem_op;
    logic ir_load;
    logic retire;
    logic stalled;

    assign adv       = bus.single_step ? (bus.step & ~step_q) : bus.run;
    // Opcodes 8'h80..8'h83 share the top six bits 100000.
    assign is_mem_op = (ir_q[15:10] == 6'b100000);

    // NOTE: every signal assigned in this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        retire  = 1'b0;
        stalled = 1'b0;
        if (adv) begin
            unique case (state_q)
                S_INIT: state_d = S_FADR;
                S_FADR: state_d = S_FRD;
                S_FRD: begin
                    if (bus.mem_ready) begin
                        state_d = S_EXEC;
                        ir_load = 1'b1;
                    end else begin
                        stalled = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_mem_op) begin
                        state_d = S_MADR;
                    end else begin
                        state_d = S_FADR;
                        retire  = 1'b1;
                    end
                end
                S_MADR: state_d = S_MDAT;
                S_MDAT: begin
                    if (bus.mem_ready) begin
                        state_d = S_FADR;
                        retire  = 1'b1;
                    end else begin
                        stalled = 1'b1;
                    end
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT;
            ir_q     <= IR_RESET;
            count_q  <= '0;
            loaded_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= bus.step;
            loaded_q <= ir_load;
            if (ir_load) ir_q    <= bus.mem_data;
            if (retire)  count_q <= count_q + 1'b1;
        end
    end

    assign bus.timer       = state_q;
    assign bus.instruction = ir_q;
    assign bus.ir_loaded   = loaded_q;
    assign bus.stalled     = stalled;
    assign bus.instr_count = count_q;

endmodule
